tia_hmove_controller: RTL and testbench

Sequences the TIA motion registers from the CPU register-write side. It decodes writes to HMP0/HMP1/HMM0/HMM1/HMBL/HMOVE/HMCLR and produces the hm strobes, data nibble, hmclr and sec (HMOVE) inputs that tia_motion_registers consumes. It also generates the HMOVE extended-blank window from its own horizontal counter. While an HMOVE extra-clock sequence is in flight it defers register writes in a one-deep pending slot, so motion values never change mid-sequence.

---
 rtl/tia_hmove_controller.sv | 180 ++++++++++++++++++
 tb/tb_tia_hmove_controller.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/tia_hmove_controller.sv
// CPU-side sequencer for the TIA motion registers: decodes HMxx/HMOVE/HMCLR writes,
// defers writes during an HMOVE sequence and generates the extended HBLANK window.
module tia_hmove_controller #(
  parameter int SEC_LEN       = 4,
  parameter int HMOVE_LEN     = 64,
  parameter int HMCLR_LEN     = 4,
  parameter int LINE_LEN      = 228,
  parameter int HBLANK_END    = 68,
  parameter int EXT_BLANK_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_stb,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       line_start,
  output logic [3:0] hm_data,
  output logic       p0hm,
  output logic       p1hm,
  output logic       m0hm,
  output logic       m1hm,
  output logic       blhm,
  output logic       hmclr,
  output logic       sec,
  output logic       hmove_blank,
  output logic       busy,
  output logic       pending,
  output logic       overflow,
  output logic       hmove_dropped
);

  localparam int BW = $clog2(HMOVE_LEN + 1);
  localparam int SW = $clog2(SEC_LEN + 1);
  localparam int CW = $clog2(HMCLR_LEN + 1);
  localparam int HW = $clog2(LINE_LEN);
  localparam logic [2:0] TGT_CLR = 3'd5;

  logic [BW-1:0] busy_cnt_reg, busy_cnt_next;
  logic [SW-1:0] sec_cnt_reg, sec_cnt_next;
  logic [CW-1:0] clr_cnt_reg, clr_cnt_next;
  logic [HW-1:0] hcount_reg, hcount_next;
  logic          pend_valid_reg, pend_valid_next;
  logic [2:0]    pend_tgt_reg, pend_tgt_next;
  logic [3:0]    pend_nib_reg, pend_nib_next;
  logic [3:0]    hm_data_reg, hm_data_next;
  logic [4:0]    strobe_reg, strobe_next;
  logic          overflow_reg, overflow_next;
  logic          dropped_reg, dropped_next;
  logic          blank_cur_reg, blank_cur_next;
  logic          blank_nxt_reg, blank_nxt_next;

  logic       busy_now, is_hm, is_clr, is_mv, is_load, issue, set_cur, set_nxt, new_line;
  logic [2:0] new_tgt, issue_tgt;
  logic [3:0] issue_nib;

  always_comb begin
    busy_now = (busy_cnt_reg != '0);
    is_hm    = wr_stb && (wr_addr >= 6'h20) && (wr_addr <= 6'h24);
    is_clr   = wr_stb && (wr_addr == 6'h2B);
    is_mv    = wr_stb && (wr_addr == 6'h2A);
    is_load  = is_hm || is_clr;
    new_tgt  = is_clr ? TGT_CLR : wr_addr[2:0];

    busy_cnt_next   = busy_now ? busy_cnt_reg - BW'(1) : '0;
    sec_cnt_next    = (sec_cnt_reg != '0) ? sec_cnt_reg - SW'(1) : '0;
    clr_cnt_next    = (clr_cnt_reg != '0) ? clr_cnt_reg - CW'(1) : '0;
    pend_valid_next = pend_valid_reg;
    pend_tgt_next   = pend_tgt_reg;
    pend_nib_next   = pend_nib_reg;
    overflow_next   = 1'b0;
    dropped_next    = 1'b0;
    issue           = 1'b0;
    issue_tgt       = pend_tgt_reg;
    issue_nib       = pend_nib_reg;
    set_cur         = 1'b0;
    set_nxt         = 1'b0;

    // A waiting entry always drains first; a coincident write simply refills the slot.
    if (pend_valid_reg && !busy_now) begin
      issue           = 1'b1;
      pend_valid_next = is_load;
      if (is_load) begin
        pend_tgt_next = new_tgt;
        pend_nib_next = wr_data[7:4];
      end
    end else if (is_load) begin
      if (!busy_now) begin
        issue     = 1'b1;
        issue_tgt = new_tgt;
        issue_nib = wr_data[7:4];
      end else begin
        overflow_next   = pend_valid_reg;
        pend_valid_next = 1'b1;
        pend_tgt_next   = new_tgt;
        pend_nib_next   = wr_data[7:4];
      end
    end

    hm_data_next = hm_data_reg;
    if (issue && issue_tgt == TGT_CLR) begin
      clr_cnt_next = CW'(HMCLR_LEN);
    end else if (issue) begin
      hm_data_next = issue_nib;
    end

    if (is_mv) begin
      if (busy_now) begin
        dropped_next = 1'b1;
      end else begin
        busy_cnt_next = BW'(HMOVE_LEN);
        sec_cnt_next  = SW'(SEC_LEN);
        if (hcount_reg < HW'(HBLANK_END)) set_cur = 1'b1;
        else                              set_nxt = 1'b1;
      end
    end

    if (line_start || hcount_reg == HW'(LINE_LEN - 1)) hcount_next = '0;
    else                                               hcount_next = hcount_reg + HW'(1);
    new_line = (hcount_next == '0);

    // The "next line" request is promoted into the current-line flag at each line start.
    blank_cur_next = blank_cur_reg;
    if (blank_cur_reg && hcount_reg == HW'(HBLANK_END + EXT_BLANK_LEN - 1)) blank_cur_next = 1'b0;
    if (set_cur) blank_cur_next = 1'b1;
    if (new_line) blank_cur_next = blank_cur_next | blank_nxt_reg | set_nxt;
    blank_nxt_next = new_line ? 1'b0 : (blank_nxt_reg | set_nxt);
  end

  for (genvar gi = 0; gi < 5; gi++) begin : g_strobe
    assign strobe_next[gi] = issue && (issue_tgt == 3'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt_reg   <= '0;
      sec_cnt_reg    <= '0;
      clr_cnt_reg    <= '0;
      hcount_reg     <= '0;
      pend_valid_reg <= 1'b0;
      pend_tgt_reg   <= '0;
      pend_nib_reg   <= '0;
      hm_data_reg    <= '0;
      strobe_reg     <= '0;
      overflow_reg   <= 1'b0;
      dropped_reg    <= 1'b0;
      blank_cur_reg  <= 1'b0;
      blank_nxt_reg  <= 1'b0;
    end else begin
      busy_cnt_reg   <= busy_cnt_next;
      sec_cnt_reg    <= sec_cnt_next;
      clr_cnt_reg    <= clr_cnt_next;
      hcount_reg     <= hcount_next;
      pend_valid_reg <= pend_valid_next;
      pend_tgt_reg   <= pend_tgt_next;
      pend_nib_reg   <= pend_nib_next;
      hm_data_reg    <= hm_data_next;
      strobe_reg     <= strobe_next;
      overflow_reg   <= overflow_next;
      dropped_reg    <= dropped_next;
      blank_cur_reg  <= blank_cur_next;
      blank_nxt_reg  <= blank_nxt_next;
    end
  end

  assign hm_data       = hm_data_reg;
  assign p0hm          = strobe_reg[0];
  assign p1hm          = strobe_reg[1];
  assign m0hm          = strobe_reg[2];
  assign m1hm          = strobe_reg[3];
  assign blhm          = strobe_reg[4];
  assign hmclr         = (clr_cnt_reg != '0);
  assign sec           = (sec_cnt_reg != '0);
  assign busy          = (busy_cnt_reg != '0);
  assign pending       = pend_valid_reg;
  assign overflow      = overflow_reg;
  assign hmove_dropped = dropped_reg;
  assign hmove_blank   = blank_cur_reg && (hcount_reg >= HW'(HBLANK_END)) &&
                         (hcount_reg < HW'(HBLANK_END + EXT_BLANK_LEN));

endmodule

// File: tb/tb_tia_hmove_controller.sv
// Directed + random bench for tia_hmove_controller against a time-window reference model
// (each output is derived from absolute cycle numbers of the events that cause it).
module tb_tia_hmove_controller;
  localparam int SEC_LEN = 4, HMOVE_LEN = 64, HMCLR_LEN = 4;
  localparam int LINE_LEN = 228, HBLANK_END = 68, EXT_BLANK_LEN = 8;

  logic clk, reset, wr_stb, line_start;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] hm_data;
  logic p0hm, p1hm, m0hm, m1hm, blhm, hmclr, sec, hmove_blank, busy, pending, overflow, hmove_dropped;

  tia_hmove_controller dut (
    .clk(clk), .reset(reset), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .line_start(line_start), .hm_data(hm_data), .p0hm(p0hm), .p1hm(p1hm), .m0hm(m0hm),
    .m1hm(m1hm), .blhm(blhm), .hmclr(hmclr), .sec(sec), .hmove_blank(hmove_blank),
    .busy(busy), .pending(pending), .overflow(overflow), .hmove_dropped(hmove_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_bad, cyc;
  // Reference state: event times, the one-deep slot, and scheduled blank-window starts.
  int m_acc_t, m_clr_t, m_t0, m_ptgt;
  bit m_pv, m_ovf, m_drop;
  logic [3:0] m_pnib, m_nib;
  logic [4:0] m_stb;
  int m_wins[$];

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit ws, input logic [5:0] a,
                            input logic [7:0] d, input bit ls);
    int tn, tgt, itgt, h, s;
    bit busy_now, is_mv, iss, seen;
    logic [3:0] inib;
    tn = cyc + 1;
    m_stb = '0; m_ovf = 0; m_drop = 0;
    if (rst) begin
      m_acc_t = -1000; m_clr_t = -1000; m_pv = 0; m_nib = '0; m_wins.delete(); m_t0 = tn;
      return;
    end
    busy_now = (cyc > m_acc_t) && (cyc <= m_acc_t + HMOVE_LEN);
    tgt = -1; is_mv = 0; iss = 0; itgt = 0; inib = '0;
    if (ws) begin
      if (a >= 6'h20 && a <= 6'h24) tgt = int'(a) - 32;
      else if (a == 6'h2B) tgt = 5;
      else if (a == 6'h2A) is_mv = 1;
    end
    if (m_pv && !busy_now) begin
      iss = 1; itgt = m_ptgt; inib = m_pnib; m_pv = 0;
      if (tgt >= 0) begin m_pv = 1; m_ptgt = tgt; m_pnib = d[7:4]; end
    end else if (tgt >= 0) begin
      if (!busy_now) begin iss = 1; itgt = tgt; inib = d[7:4]; end
      else begin m_ovf = m_pv; m_pv = 1; m_ptgt = tgt; m_pnib = d[7:4]; end
    end
    if (iss) begin
      if (itgt == 5) m_clr_t = tn;
      else begin m_stb[itgt] = 1'b1; m_nib = inib; end
    end
    if (is_mv) begin
      if (busy_now) m_drop = 1;
      else begin
        m_acc_t = cyc;
        h = (cyc - m_t0) % LINE_LEN;
        s = (h < HBLANK_END) ? cyc + HBLANK_END - h : cyc + LINE_LEN - h + HBLANK_END;
        seen = 0;
        foreach (m_wins[i]) if (m_wins[i] == s) seen = 1;
        if (!seen) m_wins.push_back(s);
      end
    end
    if (ls) m_t0 = tn;
  endtask

  function automatic logic [15:0] exp_vec();
    bit bl;
    bl = 0;
    foreach (m_wins[i]) if (cyc >= m_wins[i] && cyc < m_wins[i] + EXT_BLANK_LEN) bl = 1;
    return {m_nib, m_stb,
            1'(cyc >= m_clr_t && cyc < m_clr_t + HMCLR_LEN),
            1'(cyc > m_acc_t && cyc <= m_acc_t + SEC_LEN),
            1'(bl),
            1'(cyc > m_acc_t && cyc <= m_acc_t + HMOVE_LEN),
            1'(m_pv), 1'(m_ovf), 1'(m_drop)};
  endfunction

  task automatic step(input bit r, input bit ws, input logic [5:0] a,
                      input logic [7:0] d, input bit ls);
    reset = r; wr_stb = ws; wr_addr = a; wr_data = d; line_start = ls;
    if (ws && !r) $display("wr cyc=%0d addr=%h data=%h busy=%0b", cyc, a, d, busy);
    model_step(r, ws, a, d, ls);
    @(posedge clk);
    #1;
    cyc++;
    check_eq("outs", {hm_data, blhm, m1hm, m0hm, p1hm, p0hm, hmclr, sec, hmove_blank,
                      busy, pending, overflow, hmove_dropped}, exp_vec());
    while (m_wins.size() > 0 && m_wins[0] + EXT_BLANK_LEN < cyc) void'(m_wins.pop_front());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 6'h00, 8'h00, 0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    step(0, 1, a, d, 0);
  endtask

  task automatic wait_hc(input int h);
    for (int k = 0; k < LINE_LEN && ((cyc - m_t0) % LINE_LEN) != h; k++) idle(1);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    m_acc_t = -1000; m_clr_t = -1000; m_t0 = 0; m_pv = 0; m_ptgt = 0;
    m_pnib = '0; m_nib = '0; m_stb = '0; m_ovf = 0; m_drop = 0;
    reset = 1; wr_stb = 0; wr_addr = '0; wr_data = '0; line_start = 0;

    step(1, 0, 6'h00, 8'h00, 0);
    step(1, 1, 6'h2A, 8'h00, 0);
    step(0, 0, 6'h00, 8'h00, 1);
    idle(3);
    wr(6'h20, 8'h70); idle(2);
    wr(6'h21, 8'h00); idle(2);
    wr(6'h3F, 8'hF0); wr(6'h25, 8'hA0); idle(2);
    wait_hc(10);  wr(6'h2A, 8'h00); idle(80);
    wait_hc(100); wr(6'h2A, 8'h00); idle(250);
    // deferred write, overwrite, drain after the sequence
    wr(6'h2A, 8'h00); idle(4); wr(6'h23, 8'hC0); wr(6'h24, 8'hB0); idle(70);
    // dropped HMOVE, then HMCLR once idle
    wr(6'h2A, 8'h00); idle(9); wr(6'h2A, 8'h00); idle(59); wr(6'h2B, 8'h00); idle(2);
    wr(6'h2B, 8'h00); wr(6'h22, 8'h50); idle(8);
    // drain coinciding with a fresh write
    wr(6'h2A, 8'h00); idle(4); wr(6'h20, 8'h50); idle(59); wr(6'h21, 8'h30); idle(5);
    // drain coinciding with a new HMOVE
    wr(6'h2A, 8'h00); idle(4); wr(6'h22, 8'h90); idle(59); wr(6'h2A, 8'h00); idle(70);
    // pending HMCLR drain
    wr(6'h2A, 8'h00); idle(3); wr(6'h2B, 8'h00); idle(66);
    // reset mid-sequence discards pending entry
    wr(6'h2A, 8'h00); wr(6'h20, 8'h40); step(1, 0, 6'h00, 8'h00, 0); idle(80);

    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [5:0] a;
      if ($urandom_range(0, 599) == 0) begin
        step(1, 0, 6'h00, 8'h00, 0);
      end else if ($urandom_range(0, 99) < 40) begin
        r = $urandom_range(0, 15);
        if (r < 8)       a = 6'(6'h20 + (r % 5));
        else if (r < 10) a = 6'h2A;
        else if (r < 12) a = 6'h2B;
        else             a = 6'($urandom_range(0, 63));
        wr(a, 8'($urandom_range(0, 255)));
      end else begin
        idle(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
